// File: rtl/thermo_pkg.sv
// -----------------------------------------------------------------------------
// thermo_pkg
// Shared definitions for the thermometer scan controller:
//   state_e  - controller FSM states (IDLE, SCAN, HOLD)
//   LEVEL_W  - width needed to hold a ones-count of 0..data_width
// -----------------------------------------------------------------------------
package thermo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Bits needed to represent every value 0..data_width inclusive.
    function automatic int LEVEL_W(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/thermo_sat_counter.sv
// -----------------------------------------------------------------------------
// thermo_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset, clears the count
//   inc     - add one this cycle (ignored once saturated)
//   count   - current tally
// -----------------------------------------------------------------------------
module thermo_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/thermometer_scan_controller.sv
// -----------------------------------------------------------------------------
// thermometer_scan_controller
// Accepts a code over a valid/ready handshake, walks it one bit per cycle
// (LSB first, always DATA_WIDTH cycles) to decide whether it is a legal
// thermometer code, then holds the verdict until the consumer takes it and
// tallies passes and fails in saturating counters.
//
// Optional feature macro: THERMO_INVERT_EN
//   defined   - runs of ones aligned to the MSB also pass
//   undefined - only runs of ones aligned to bit 0 pass
//
// Ports:
//   clk            - clock, rising edge
//   resetn         - asynchronous active-low reset
//   code_in        - candidate code, captured only on the input handshake
//   in_valid       - code_in valid
//   in_ready       - controller is idle and can accept a code
//   out_valid      - verdict valid
//   out_ready      - consumer accepts the verdict
//   is_thermometer - captured code was legal (0 while out_valid is 0)
//   level          - ones in a legal code, 0 when illegal or not valid
//   pass_count     - saturating count of legal verdicts delivered
//   fail_count     - saturating count of illegal verdicts delivered
// -----------------------------------------------------------------------------
module thermometer_scan_controller
    import thermo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [DATA_WIDTH-1:0]            code_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             is_thermometer,
    output logic [LEVEL_W(DATA_WIDTH)-1:0]   level,
    output logic [CNT_WIDTH-1:0]             pass_count,
    output logic [CNT_WIDTH-1:0]             fail_count
);

    localparam int            LW       = LEVEL_W(DATA_WIDTH);
    localparam logic [LW-1:0] LAST_IDX = LW'(DATA_WIDTH - 1);

    state_e                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   shift_q,     shift_d;
    logic [LW-1:0]           idx_q,       idx_d;
    logic [LW-1:0]           ones_q,      ones_d;
    logic                    seen_zero_q, seen_zero_d;
    logic                    lsb_bad_q,   lsb_bad_d;
`ifdef THERMO_INVERT_EN
    logic                    seen_one_q,  seen_one_d;
    logic                    msb_bad_q,   msb_bad_d;
`endif
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    is_therm_q,  is_therm_d;
    logic [LW-1:0]           level_q,     level_d;

    logic                    in_hs;
    logic                    out_hs;
    logic                    scan_bit;
    logic [LW-1:0]           ones_next;
    logic                    lsb_bad_next;
    logic                    pass_final;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        seen_zero_d = seen_zero_q;
        lsb_bad_d   = lsb_bad_q;
`ifdef THERMO_INVERT_EN
        seen_one_d  = seen_one_q;
        msb_bad_d   = msb_bad_q;
`endif
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        is_therm_d  = is_therm_q;
        level_d     = level_q;

        // Bit under examination this SCAN cycle; the shift register moves
        // the next bit into position 0 every cycle.
        scan_bit  = shift_q[0];
        ones_next = ones_q + LW'(scan_bit);

        // LSB-aligned rule: bit 0 must be 1, and no 1 may appear after a 0.
        lsb_bad_next = lsb_bad_q
                     | ((idx_q == '0) && !scan_bit)
                     | (scan_bit && seen_zero_q);

`ifdef THERMO_INVERT_EN
        // MSB-aligned rule: once a 1 is seen no 0 may follow, and the code
        // must be nonzero (checked on the final ones count).
        pass_final = !lsb_bad_next
                   || (!(msb_bad_q || (!scan_bit && seen_one_q)) && (ones_next != '0));
`else
        pass_final = !lsb_bad_next;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    state_d     = ST_SCAN;
                    shift_d     = code_in;
                    idx_d       = '0;
                    ones_d      = '0;
                    seen_zero_d = 1'b0;
                    lsb_bad_d   = 1'b0;
`ifdef THERMO_INVERT_EN
                    seen_one_d  = 1'b0;
                    msb_bad_d   = 1'b0;
`endif
                    in_ready_d  = 1'b0;
                end
            end

            ST_SCAN: begin
                shift_d     = shift_q >> 1;
                idx_d       = idx_q + LW'(1);
                ones_d      = ones_next;
                seen_zero_d = seen_zero_q | !scan_bit;
                lsb_bad_d   = lsb_bad_next;
`ifdef THERMO_INVERT_EN
                seen_one_d  = seen_one_q | scan_bit;
                msb_bad_d   = msb_bad_q | (!scan_bit && seen_one_q);
`endif
                // No early exit: the verdict always lands on the last bit,
                // giving a latency that does not depend on the code.
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    is_therm_d  = pass_final;
                    level_d     = pass_final ? ones_next : '0;
                end
            end

            ST_HOLD: begin
                if (out_hs) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    is_therm_d  = 1'b0;
                    level_d     = '0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                is_therm_d  = 1'b0;
                level_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            ones_q      <= '0;
            seen_zero_q <= 1'b0;
            lsb_bad_q   <= 1'b0;
`ifdef THERMO_INVERT_EN
            seen_one_q  <= 1'b0;
            msb_bad_q   <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            is_therm_q  <= 1'b0;
            level_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            seen_zero_q <= seen_zero_d;
            lsb_bad_q   <= lsb_bad_d;
`ifdef THERMO_INVERT_EN
            seen_one_q  <= seen_one_d;
            msb_bad_q   <= msb_bad_d;
`endif
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            is_therm_q  <= is_therm_d;
            level_q     <= level_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign is_thermometer = is_therm_q;
    assign level          = level_q;

    thermo_sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_hs && is_therm_q),
        .count  (pass_count)
    );

    thermo_sat_counter #(.WIDTH(CNT_WIDTH)) u_fail_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_hs && !is_therm_q),
        .count  (fail_count)
    );

endmodule

// File: doc/thermometer_scan_controller.md
THERMOMETER_SCAN_CONTROLLER -- requirements
Module: thermometer_scan_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the code width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the pass and fail counters.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 code_in  input  DATA_WIDTH  candidate code, sampled only on input handshake.
REQ-006 in_valid  input  1  code_in valid.
REQ-007 in_ready  output  1  block can accept a code.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 is_thermometer  output  1  result: captured code is a legal thermometer code.
REQ-011 level  output  $clog2(DATA_WIDTH+1)  number of ones in a legal code; 0 when illegal.
REQ-012 pass_count, fail_count  output  CNT_WIDTH each  saturating result tallies.

Function
REQ-013 Legal code SHALL be nonzero with ones contiguous from bit 0 (value 2^k-1, 1<=k<=DATA_WIDTH); all-zero SHALL be illegal.
REQ-014 FSM states SHALL be IDLE, SCAN, HOLD; IDLE->SCAN on in_valid&&in_ready; SCAN->HOLD after DATA_WIDTH scan cycles; HOLD->IDLE on out_valid&&out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; code_in SHALL be registered on the accepting edge and ignored at all other times.
REQ-016 SCAN SHALL examine one bit per cycle, LSB first: fail if bit 0 is 0, or a 1 follows any 0; no early exit.
REQ-017 out_valid SHALL rise on the DATA_WIDTH-th rising edge after the accepting edge (fixed latency, independent of code value).
REQ-018 In HOLD, out_valid, is_thermometer and level SHALL remain stable until out_ready is sampled high.
REQ-019 On the output handshake edge, pass_count or fail_count SHALL increment by one, saturating at all-ones with no wrap.
REQ-020 After the output handshake, in_ready SHALL assert the next cycle; there is no same-cycle output-to-input bypass.
REQ-021 is_thermometer and level SHALL be 0 whenever out_valid is 0.

Reset
REQ-022 resetn low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, is_thermometer=0, level=0, and both counters to 0.
REQ-023 Reset asserted during SCAN or HOLD SHALL discard the in-flight code and leave both counters at 0.

Configuration
REQ-024 Macro THERMO_INVERT_EN defined: MSB-aligned runs SHALL also pass, with level equal to the count of ones.
- Example: 8'b1110_0000 gives pass, level 3.
REQ-025 Macro THERMO_INVERT_EN undefined: only LSB-aligned codes SHALL pass.
REQ-026 All-ones SHALL pass with level=DATA_WIDTH whether or not THERMO_INVERT_EN is defined.

Structure
REQ-027 Package thermo_pkg SHALL hold the FSM state enum typedef and a LEVEL_W width function.
REQ-028 The saturating counter SHALL be sub-module thermo_sat_counter, instantiated twice (pass, fail).

Verification (DATA_WIDTH=8)
REQ-029 code 8'b0000_0111 accepted -> out_valid 8 edges later, is_thermometer=1, level=3; pass_count=1 after handshake.
REQ-030 8'b0000_0101, then 8'h00 -> is_thermometer=0, level=0 each; fail_count=2; 8'hFF -> pass, level=8.
REQ-031 8'b1110_0000 -> fail without THERMO_INVERT_EN; pass, level=3 with it.
REQ-032 out_ready held low 5 cycles in HOLD, code_in toggling -> outputs stable, in_ready=0, counters unchanged.
REQ-033 resetn pulsed low at scan cycle 4 -> all outputs 0 immediately; in_ready=1 after release; counters 0.
REQ-034 CNT_WIDTH=2, 5 legal codes -> pass_count sequence 1,2,3,3,3.
